warp_issue_scheduler: RTL and testbench
=======================================

# warp_issue_scheduler

Per-engine warp scheduler that picks which resident warp issues its next instruction bundle into the dual-issue execution engine. It tracks per-warp residency and outstanding long-latency operations (TEX/LOAD), and arbitrates eligible warps by priority with a round-robin tie-break. It presents one registered issue slot to the engine over a valid/ready handshake, plus occupancy, error and performance status.

## Interface
- NUM_WARPS, 8, resident warp slots (power of two, 2..16)
- WARP_ID_W, $clog2(NUM_WARPS), warp id width
- PRIO_W, 4, static priority width
- MAX_OUTSTANDING, 4, long-latency ops in flight per warp
- AGE_MAX, 15, starvation age threshold (aging build only)

- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- launch_valid  in  1  launch request pulse
- launch_warp  in  WARP_ID_W  warp slot to launch
- launch_prio  in  PRIO_W  static priority, higher wins
- retire_valid  in  1  retire pulse
- retire_warp  in  WARP_ID_W  warp slot to free
- fetch_rdy  in  NUM_WARPS  per-warp instruction bundle available
- lat_req_valid  in  1  engine started long-latency op
- lat_req_warp  in  WARP_ID_W  owning warp
- lat_done_valid  in  1  long-latency op completed
- lat_done_warp  in  WARP_ID_W  owning warp
- issue_valid  out  1  issue slot occupied
- issue_warp  out  WARP_ID_W  warp granted
- issue_ready  in  1  engine accepts slot
- active_warps  out  8  count of non-FREE warps
- busy  out  1  any warp non-FREE
- err_overflow  out  1  sticky: lat_req at MAX_OUTSTANDING
- err_underflow  out  1  sticky: lat_done with count 0
- idle_cycles  out  32  cycles with ≥1 ACTIVE warp but no eligible warp

## Operation
- Per-warp state (FREE, ACTIVE, WAIT_MEM), outstanding counter, priority, and age.
- Launch to FREE → ACTIVE, count 0, age 0, priority latched. Launch to non-FREE is ignored.
- Retire → FREE, count and age cleared, from any state. Retire and launch to the same warp in the same cycle: retire wins.
- lat_req: count+1, state becomes WAIT_MEM.
  - At MAX_OUTSTANDING the count holds and err_overflow is set.
- lat_done: count−1. A resulting count of 0 returns the warp to ACTIVE.
  - lat_done with count 0 sets err_underflow; the count stays 0.
- lat_req and lat_done to the same warp in the same cycle: net count unchanged, state WAIT_MEM if the count is nonzero.
- Requests to a FREE warp are ignored; the error flags are unaffected.
- Eligible(w) = ACTIVE && fetch_rdy[w] && !(lat_req_valid && lat_req_warp == w).
- Selection:
  - Winner is the highest effective priority among eligible warps.
  - Ties go to the first warp at or after rr_ptr+1, wrapping modulo NUM_WARPS.
  - On each load of the slot, rr_ptr becomes the granted warp.
- The slot loads when it is empty, or when issue_valid && issue_ready, and an eligible warp exists. The same warp may be granted back-to-back.
- While issue_valid && !issue_ready, issue_warp is held stable and no selection occurs.
  - Retiring the held warp does not cancel the slot.
- idle_cycles increments, wrapping, in any cycle with ≥1 ACTIVE warp and zero eligible warps.
- Error flags clear only on reset.

## Timing
- Reset values:
  - issue_valid 0, issue_warp 0
  - active_warps 0, busy 0
  - err flags 0, idle_cycles 0
  - all warps FREE, rr_ptr = NUM_WARPS−1, so warp 0 wins the first tie.
- Eligibility in cycle N → issue_valid/issue_warp registered at edge N+1. Throughput is one grant per cycle under continuous issue_ready.
- active_warps and busy are registered; they reflect a launch or retire one cycle after its pulse.
- Reset asserted mid-operation drops the slot and all state immediately; no drain.

## Configuration
- WARP_SCHED_AGING_EN defined:
  - age[w] increments, saturating at AGE_MAX, in each cycle the warp is eligible but not granted. It clears on grant.
  - A warp at AGE_MAX outranks every non-aged warp. Among aged warps the round-robin order applies.
- WARP_SCHED_AGING_EN undefined: no age registers; effective priority = latched priority.

## Structure
- Shared package gpu_sched_pkg holds:
  - warp_state_e enum (FREE, ACTIVE, WAIT_MEM)
  - per-warp record typedef (state, count, prio, age)
  - default NUM_WARPS, PRIO_W, MAX_OUTSTANDING, AGE_MAX constants
- One combinational sub-module rr_priority_picker: eligible mask, effective priorities and rr_ptr in; grant_valid and grant_id out.

## Test plan
- Launch warps 0..3 at prio 8, all fetch_rdy high, issue_ready high → grants 0,1,2,3,0 starting the cycle after launch; active_warps = 4.
- Warps 1 (prio 12) and 2 (prio 8) eligible → warp 1 granted every cycle. With aging enabled, warp 2 is granted after 15 losing cycles, then warp 1 resumes.
- issue_ready low for 5 cycles with warp 3 held → issue_warp stays 3. Retiring warp 3 meanwhile still completes the slot when ready rises.
- lat_req warp 0 ×2, then lat_done ×1 → still WAIT_MEM and never granted. Second lat_done → ACTIVE, granted next cycle.
- lat_req warp 0 ×5 → err_overflow = 1 and the count holds at 4. lat_done to warp 1 with count 0 → err_underflow = 1.
- Same-cycle launch and retire of warp 5 → stays FREE. Reset mid-stream with issue_valid = 1 → all outputs return to their reset values.

Source files
------------

// File: rtl/warp_issue_scheduler_pkg.sv
// Shared types and default sizing for the warp issue scheduler.
// Record field widths cover the full legal parameter range of the scheduler.
package gpu_sched_pkg;

  localparam int unsigned DEF_NUM_WARPS       = 8;
  localparam int unsigned DEF_PRIO_W          = 4;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_AGE_MAX         = 15;

  localparam int unsigned REC_CNT_W  = 5;
  localparam int unsigned REC_PRIO_W = 8;
  localparam int unsigned REC_AGE_W  = 8;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    ACTIVE   = 2'd1,
    WAIT_MEM = 2'd2
  } warp_state_e;

  typedef struct packed {
    warp_state_e           state;
    logic [REC_CNT_W-1:0]  count;
    logic [REC_PRIO_W-1:0] prio;
    logic [REC_AGE_W-1:0]  age;
  } warp_rec_t;

  localparam warp_rec_t REC_RESET = '{state: FREE, count: '0, prio: '0, age: '0};

endpackage

// File: rtl/warp_issue_scheduler_if.sv
// Issue-slot handshake between the warp scheduler (master) and the execution engine (slave).
interface warp_issue_scheduler_if
  import gpu_sched_pkg::*;
#(
  parameter int unsigned WARP_ID_W = $clog2(DEF_NUM_WARPS)
);
  logic                 issue_valid;
  logic [WARP_ID_W-1:0] issue_warp;
  logic                 issue_ready;

  modport master (output issue_valid, output issue_warp, input issue_ready);
  modport slave  (input issue_valid, input issue_warp, output issue_ready);
endinterface

// File: rtl/warp_issue_scheduler_picker.sv
// Combinational arbiter: highest effective priority wins, ties resolved in
// round-robin order starting at rr_ptr+1.
module rr_priority_picker #(
  parameter int unsigned NUM_WARPS = 8,
  parameter int unsigned WARP_ID_W = 3,
  parameter int unsigned EP_W      = 9
) (
  input  logic [NUM_WARPS-1:0]           eligible,
  input  logic [NUM_WARPS-1:0][EP_W-1:0] eff_prio,
  input  logic [WARP_ID_W-1:0]           rr_ptr,
  output logic                           grant_valid,
  output logic [WARP_ID_W-1:0]           grant_id
);
  logic [WARP_ID_W-1:0] idx;
  logic [EP_W-1:0]      best;

  // Scanning in rr order and replacing only on strictly greater keeps the first tie.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    best        = '0;
    idx         = '0;
    for (int unsigned k = 1; k <= NUM_WARPS; k++) begin
      idx = rr_ptr + WARP_ID_W'(k);
      if (eligible[idx] && (!grant_valid || eff_prio[idx] > best)) begin
        grant_valid = 1'b1;
        grant_id    = idx;
        best        = eff_prio[idx];
      end
    end
  end
endmodule

// File: rtl/warp_issue_scheduler.sv
// Per-engine warp scheduler: residency, outstanding long-latency tracking and a registered issue slot.
// Optional build macro WARP_SCHED_AGING_EN adds starvation aging to the priority.
module warp_issue_scheduler
  import gpu_sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS       = DEF_NUM_WARPS,
  parameter int unsigned WARP_ID_W       = $clog2(NUM_WARPS),
  parameter int unsigned PRIO_W          = DEF_PRIO_W,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned AGE_MAX         = DEF_AGE_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  launch_valid,
  input  logic [WARP_ID_W-1:0]  launch_warp,
  input  logic [PRIO_W-1:0]     launch_prio,
  input  logic                  retire_valid,
  input  logic [WARP_ID_W-1:0]  retire_warp,
  input  logic [NUM_WARPS-1:0]  fetch_rdy,
  input  logic                  lat_req_valid,
  input  logic [WARP_ID_W-1:0]  lat_req_warp,
  input  logic                  lat_done_valid,
  input  logic [WARP_ID_W-1:0]  lat_done_warp,
  warp_issue_scheduler_if.master issue,
  output logic [7:0]            active_warps,
  output logic                  busy,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [31:0]           idle_cycles
);
  localparam int unsigned EP_W = REC_PRIO_W + 1;

  warp_rec_t rec_q [NUM_WARPS];
  warp_rec_t rec_d [NUM_WARPS];

  logic [NUM_WARPS-1:0]           launch_hit, retire_hit, req_hit, done_hit;
  logic [NUM_WARPS-1:0]           eligible, granted;
  logic [NUM_WARPS-1:0][EP_W-1:0] eff_prio;
  logic                           grant_valid, load_en, any_active, ovf_hit, unf_hit;
  logic [WARP_ID_W-1:0]           grant_id, rr_ptr;
  logic [7:0]                     active_d;

  always_comb begin
    launch_hit = '0;
    retire_hit = '0;
    req_hit    = '0;
    done_hit   = '0;
    eligible   = '0;
    eff_prio   = '0;
    any_active = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      launch_hit[w] = launch_valid   && (launch_warp   == WARP_ID_W'(w));
      retire_hit[w] = retire_valid   && (retire_warp   == WARP_ID_W'(w));
      req_hit[w]    = lat_req_valid  && (lat_req_warp  == WARP_ID_W'(w));
      done_hit[w]   = lat_done_valid && (lat_done_warp == WARP_ID_W'(w));
      eligible[w]   = (rec_q[w].state == ACTIVE) && fetch_rdy[w] && !req_hit[w];
      any_active    = any_active || (rec_q[w].state == ACTIVE);
`ifdef WARP_SCHED_AGING_EN
      // Aged warps share one top level so round-robin alone orders them.
      eff_prio[w] = (rec_q[w].age == REC_AGE_W'(AGE_MAX)) ? {1'b1, {REC_PRIO_W{1'b0}}}
                                                          : {1'b0, rec_q[w].prio};
`else
      eff_prio[w] = {1'b0, rec_q[w].prio};
`endif
    end
  end

  rr_priority_picker #(
    .NUM_WARPS (NUM_WARPS),
    .WARP_ID_W (WARP_ID_W),
    .EP_W      (EP_W)
  ) u_picker (
    .eligible    (eligible),
    .eff_prio    (eff_prio),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign load_en = !issue.issue_valid || issue.issue_ready;

  always_comb begin
    granted = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++)
      granted[w] = load_en && grant_valid && (grant_id == WARP_ID_W'(w));
  end

  always_comb begin
    ovf_hit  = 1'b0;
    unf_hit  = 1'b0;
    active_d = '0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      rec_d[w] = rec_q[w];
      if (retire_hit[w]) begin
        rec_d[w].state = FREE;
        rec_d[w].count = '0;
        rec_d[w].age   = '0;
      end else if (rec_q[w].state == FREE) begin
        if (launch_hit[w]) begin
          rec_d[w].state = ACTIVE;
          rec_d[w].count = '0;
          rec_d[w].age   = '0;
          rec_d[w].prio  = REC_PRIO_W'(launch_prio);
        end
      end else begin
`ifdef WARP_SCHED_AGING_EN
        if (granted[w])
          rec_d[w].age = '0;
        else if (eligible[w] && rec_q[w].age != REC_AGE_W'(AGE_MAX))
          rec_d[w].age = rec_q[w].age + 1'b1;
`endif
        if (req_hit[w] && !done_hit[w]) begin
          if (rec_q[w].count == REC_CNT_W'(MAX_OUTSTANDING))
            ovf_hit = 1'b1;
          else
            rec_d[w].count = rec_q[w].count + 1'b1;
          rec_d[w].state = WAIT_MEM;
        end else if (done_hit[w] && !req_hit[w]) begin
          if (rec_q[w].count == '0) begin
            unf_hit = 1'b1;
          end else begin
            rec_d[w].count = rec_q[w].count - 1'b1;
            if (rec_q[w].count == REC_CNT_W'(1))
              rec_d[w].state = ACTIVE;
          end
        end else if (req_hit[w] && done_hit[w]) begin
          rec_d[w].state = (rec_q[w].count != '0) ? WAIT_MEM : ACTIVE;
        end
      end
      if (rec_d[w].state != FREE)
        active_d = active_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++)
        rec_q[w] <= REC_RESET;
      rr_ptr            <= '1;
      issue.issue_valid <= 1'b0;
      issue.issue_warp  <= '0;
      active_warps      <= '0;
      busy              <= 1'b0;
      err_overflow      <= 1'b0;
      err_underflow     <= 1'b0;
      idle_cycles       <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++)
        rec_q[w] <= rec_d[w];
      // A held slot (valid && !ready) survives even if its warp retires.
      if (load_en) begin
        issue.issue_valid <= grant_valid;
        if (grant_valid) begin
          issue.issue_warp <= grant_id;
          rr_ptr           <= grant_id;
        end
      end
      active_warps <= active_d;
      busy         <= (active_d != '0);
      if (ovf_hit) err_overflow  <= 1'b1;
      if (unf_hit) err_underflow <= 1'b1;
      if (any_active && (eligible == '0))
        idle_cycles <= idle_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: directed scenarios plus random traffic against a behavioural model.
module tb_warp_issue_scheduler;
  localparam int NW   = 8;
  localparam int IDW  = 3;
  localparam int PW   = 4;
  localparam int MAXO = 4;
  localparam int AGEM = 15;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           launch_valid = 1'b0;
  logic [IDW-1:0] launch_warp = '0;
  logic [PW-1:0]  launch_prio = '0;
  logic           retire_valid = 1'b0;
  logic [IDW-1:0] retire_warp = '0;
  logic [NW-1:0]  fetch_rdy = '0;
  logic           lat_req_valid = 1'b0;
  logic [IDW-1:0] lat_req_warp = '0;
  logic           lat_done_valid = 1'b0;
  logic [IDW-1:0] lat_done_warp = '0;
  logic [7:0]     active_warps;
  logic           busy, err_overflow, err_underflow;
  logic [31:0]    idle_cycles;

  always #5 clk = ~clk;

  warp_issue_scheduler_if #(.WARP_ID_W(IDW)) issue_if ();

  warp_issue_scheduler #(
    .NUM_WARPS(NW), .WARP_ID_W(IDW), .PRIO_W(PW), .MAX_OUTSTANDING(MAXO), .AGE_MAX(AGEM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .launch_valid(launch_valid), .launch_warp(launch_warp), .launch_prio(launch_prio),
    .retire_valid(retire_valid), .retire_warp(retire_warp),
    .fetch_rdy(fetch_rdy),
    .lat_req_valid(lat_req_valid), .lat_req_warp(lat_req_warp),
    .lat_done_valid(lat_done_valid), .lat_done_warp(lat_done_warp),
    .issue(issue_if),
    .active_warps(active_warps), .busy(busy),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .idle_cycles(idle_cycles)
  );

  int compared = 0;
  int mismatched = 0;

  // Model: state 0=free, 1=runnable, 2=waiting on memory.
  int          m_st[NW], m_cnt[NW], m_prio[NW], m_age[NW];
  int          m_iv, m_iw, m_rr, m_ovf, m_unf, m_active;
  logic [31:0] m_idle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < NW; w++) begin
      m_st[w] = 0; m_cnt[w] = 0; m_prio[w] = 0; m_age[w] = 0;
    end
    m_iv = 0; m_iw = 0; m_rr = NW - 1; m_ovf = 0; m_unf = 0; m_active = 0; m_idle = 0;
  endtask

  function automatic int effp(input int w);
`ifdef WARP_SCHED_AGING_EN
    if (m_age[w] >= AGEM) return 1000;
`endif
    return m_prio[w];
  endfunction

  task automatic step();
    int elig[NW];
    int best, bestp, w, load, any_act, any_elig, q, d;
    any_act = 0; any_elig = 0;
    for (int i = 0; i < NW; i++) begin
      elig[i] = (m_st[i] == 1 && fetch_rdy[i] && !(lat_req_valid && lat_req_warp == i)) ? 1 : 0;
      if (m_st[i] == 1) any_act = 1;
      if (elig[i] != 0) any_elig = 1;
    end
    load = (m_iv == 0 || issue_if.issue_ready) ? 1 : 0;
    best = -1; bestp = 0;
    for (int k = 1; k <= NW; k++) begin
      w = (m_rr + k) % NW;
      if (elig[w] != 0 && (best < 0 || effp(w) > bestp)) begin
        best = w; bestp = effp(w);
      end
    end
    for (int i = 0; i < NW; i++) begin
      q = (lat_req_valid && lat_req_warp == i) ? 1 : 0;
      d = (lat_done_valid && lat_done_warp == i) ? 1 : 0;
      if (retire_valid && retire_warp == i) begin
        m_st[i] = 0; m_cnt[i] = 0; m_age[i] = 0;
      end else if (m_st[i] == 0) begin
        if (launch_valid && launch_warp == i) begin
          m_st[i] = 1; m_cnt[i] = 0; m_age[i] = 0; m_prio[i] = launch_prio;
        end
      end else begin
`ifdef WARP_SCHED_AGING_EN
        if (load != 0 && best == i) m_age[i] = 0;
        else if (elig[i] != 0) m_age[i] = (m_age[i] + 1 > AGEM) ? AGEM : m_age[i] + 1;
`endif
        if (q != 0 && d == 0 && m_cnt[i] == MAXO) m_ovf = 1;
        else if (d != 0 && q == 0 && m_cnt[i] == 0) m_unf = 1;
        else m_cnt[i] = m_cnt[i] + q - d;
        if (q != 0 || d != 0) m_st[i] = (m_cnt[i] > 0) ? 2 : 1;
      end
    end
    if (load != 0) begin
      m_iv = (best >= 0) ? 1 : 0;
      if (best >= 0) begin m_iw = best; m_rr = best; end
    end
    if (any_act != 0 && any_elig == 0) m_idle = m_idle + 32'd1;
    m_active = 0;
    for (int i = 0; i < NW; i++) if (m_st[i] != 0) m_active++;

    @(posedge clk);
    #1;
    check("issue_valid", 32'(issue_if.issue_valid), 32'(m_iv));
    if (m_iv != 0) check("issue_warp", 32'(issue_if.issue_warp), 32'(m_iw));
    check("active_warps", 32'(active_warps), 32'(m_active));
    check("busy", 32'(busy), 32'(m_active > 0));
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("err_underflow", 32'(err_underflow), 32'(m_unf));
    check("idle_cycles", idle_cycles, m_idle);
  endtask

  task automatic check_reset_values();
    check("rst_issue_valid", 32'(issue_if.issue_valid), 32'd0);
    check("rst_issue_warp", 32'(issue_if.issue_warp), 32'd0);
    check("rst_active_warps", 32'(active_warps), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_overflow", 32'(err_overflow), 32'd0);
    check("rst_err_underflow", 32'(err_underflow), 32'd0);
    check("rst_idle_cycles", idle_cycles, 32'd0);
  endtask

  task automatic launch(input int w, input int p);
    launch_valid = 1'b1; launch_warp = IDW'(w); launch_prio = PW'(p);
    step();
    launch_valid = 1'b0;
  endtask

  task automatic retire(input int w);
    retire_valid = 1'b1; retire_warp = IDW'(w);
    step();
    retire_valid = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      launch_valid   = ($urandom_range(0, 9) < 3);
      launch_warp    = IDW'($urandom_range(0, NW - 1));
      launch_prio    = PW'($urandom);
      retire_valid   = ($urandom_range(0, 9) == 0);
      retire_warp    = IDW'($urandom_range(0, NW - 1));
      lat_req_valid  = ($urandom_range(0, 3) == 0);
      lat_req_warp   = IDW'($urandom_range(0, NW - 1));
      lat_done_valid = ($urandom_range(0, 3) == 0);
      lat_done_warp  = IDW'($urandom_range(0, NW - 1));
      fetch_rdy      = NW'($urandom);
      issue_if.issue_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    launch_valid = 1'b0; retire_valid = 1'b0;
    lat_req_valid = 1'b0; lat_done_valid = 1'b0;
  endtask

  initial begin
    int exp_seq[5];
    int exp_w;
    exp_seq = '{0, 1, 2, 3, 0};
    issue_if.issue_ready = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // Four equal-priority warps rotate starting at warp 0.
    for (int i = 0; i < 4; i++) launch(i, 8);
    check("launch4_active", 32'(active_warps), 32'd4);
    check("launch4_busy", 32'(busy), 32'd1);
    fetch_rdy = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_valid", 32'(issue_if.issue_valid), 32'd1);
      check("rr_warp", 32'(issue_if.issue_warp), 32'(exp_seq[i]));
    end

    // Priority: warp 1 (12) over warp 2 (8); aging lets warp 2 through on grant 16.
    fetch_rdy = '0;
    for (int i = 0; i < 4; i++) retire(i);
    launch(1, 12);
    launch(2, 8);
    fetch_rdy = 8'b0000_0110;
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_w = 1;
`ifdef WARP_SCHED_AGING_EN
      if (k == 16) exp_w = 2;
`endif
      check("prio_warp", 32'(issue_if.issue_warp), 32'(exp_w));
    end

    // Stalled slot holds warp 3, even across its retirement.
    fetch_rdy = '0;
    retire(1);
    retire(2);
    launch(3, 5);
    fetch_rdy = 8'b0000_1000;
    step();
    check("hold_load_warp", 32'(issue_if.issue_warp), 32'd3);
    issue_if.issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      retire_valid = (i == 1); retire_warp = 3'd3;
      step();
      check("hold_valid", 32'(issue_if.issue_valid), 32'd1);
      check("hold_warp", 32'(issue_if.issue_warp), 32'd3);
    end
    retire_valid = 1'b0;
    issue_if.issue_ready = 1'b1;
    step();
    check("hold_drained", 32'(issue_if.issue_valid), 32'd0);

    // Outstanding ops block issue until the count returns to zero.
    fetch_rdy = 8'b0000_0001;
    launch(0, 8);
    lat_req_valid = 1'b1; lat_req_warp = 3'd0;
    step();
    check("mem_blocked0", 32'(issue_if.issue_valid), 32'd0);
    step();
    lat_req_valid = 1'b0;
    lat_done_valid = 1'b1; lat_done_warp = 3'd0;
    step();
    lat_done_valid = 1'b0;
    step();
    check("mem_blocked1", 32'(issue_if.issue_valid), 32'd0);
    lat_done_valid = 1'b1;
    step();
    check("mem_last_done", 32'(issue_if.issue_valid), 32'd0);
    lat_done_valid = 1'b0;
    step();
    check("mem_resume_valid", 32'(issue_if.issue_valid), 32'd1);
    check("mem_resume_warp", 32'(issue_if.issue_warp), 32'd0);

    // Overflow at the fifth request; count holds at four.
    lat_req_valid = 1'b1; lat_req_warp = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 4) check("ovf_before", 32'(err_overflow), 32'd0);
    end
    check("ovf_after", 32'(err_overflow), 32'd1);
    lat_req_valid = 1'b0;
    lat_done_valid = 1'b1; lat_done_warp = 3'd0;
    for (int i = 1; i <= 4; i++) step();
    check("ovf_drain_blocked", 32'(issue_if.issue_valid), 32'd0);
    lat_done_valid = 1'b0;
    step();
    check("ovf_drain_resume", 32'(issue_if.issue_valid), 32'd1);

    // Underflow on a resident warp with nothing outstanding.
    check("unf_before", 32'(err_underflow), 32'd0);
    launch(1, 2);
    lat_done_valid = 1'b1; lat_done_warp = 3'd1;
    step();
    lat_done_valid = 1'b0;
    check("unf_after", 32'(err_underflow), 32'd1);

    // Retire beats launch on the same warp.
    launch_valid = 1'b1; launch_warp = 3'd5; launch_prio = 4'd9;
    retire_valid = 1'b1; retire_warp = 3'd5;
    step();
    launch_valid = 1'b0; retire_valid = 1'b0;
    step();
    check("launch_retire_active", 32'(active_warps), 32'd2);

    random_cycles(2000);

    // Reset asserted while the slot is occupied.
    fetch_rdy = '1;
    issue_if.issue_ready = 1'b1;
    retire(6);
    launch(6, 3);
    step();
    check("pre_reset_valid", 32'(issue_if.issue_valid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    random_cycles(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
